seq_commit_unit: RTL and testbench



---
 rtl/seq_commit_unit.sv | 124 ++++++++++++
 tb/tb_seq_commit_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/seq_commit_unit.sv
// rtl/seq_commit_unit.sv - in-order commit window: sequence allocation, completion tracking, squash
// Oldest-first retirement; commit_* is the notification every age-comparing consumer listens to.
module seq_commit_unit #(
  parameter int p_seq_num_bits = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_val,
  output logic                      alloc_rdy,
  output logic [p_seq_num_bits-1:0] alloc_seq_num,
  input  logic                      complete_val,
  input  logic [p_seq_num_bits-1:0] complete_seq_num,
  input  logic [31:0]               complete_pc,
  input  logic [4:0]                complete_waddr,
  input  logic [31:0]               complete_wdata,
  input  logic                      complete_wen,
  input  logic                      squash_val,
  input  logic [p_seq_num_bits-1:0] squash_seq_num,
  output logic                      commit_val,
  output logic [p_seq_num_bits-1:0] commit_seq_num,
  output logic [31:0]               commit_pc,
  output logic [4:0]                commit_waddr,
  output logic [31:0]               commit_wdata,
  output logic                      commit_wen
);

  localparam int N = p_seq_num_bits;
  localparam int D = 1 << N;

  logic [D-1:0]  alloc_q;
  logic [D-1:0]  done_q;
  logic [31:0]   pc_q    [D];
  logic [4:0]    waddr_q [D];
  logic [31:0]   wdata_q [D];
  logic [D-1:0]  wen_q;
  logic [N-1:0]  head_q;
  logic [N-1:0]  tail_q;
  logic [N:0]    count_q;

  logic          alloc_fire;
  logic          squash_ok;
  logic [N-1:0]  rel_sq;
  logic [D-1:0]  younger;
  logic [N:0]    count_d;

  // alloc_rdy depends only on registered count and the raw squash request, never on commit
  assign alloc_rdy     = (count_q != (N+1)'(D)) & ~squash_val;
  assign alloc_seq_num = tail_q;
  assign alloc_fire    = alloc_val & alloc_rdy;

  assign commit_val     = alloc_q[head_q] & done_q[head_q];
  assign commit_seq_num = head_q;
  assign commit_pc      = pc_q[head_q];
  assign commit_waddr   = waddr_q[head_q];
  assign commit_wdata   = wdata_q[head_q];
  assign commit_wen     = wen_q[head_q];

  // A squash naming a number that is not in flight is ignored entirely
  assign squash_ok = squash_val & alloc_q[squash_seq_num];
  assign rel_sq    = squash_seq_num - head_q;

  always_comb begin
    younger = '0;
    for (int i = 0; i < D; i++) begin
      younger[i] = (N'(i) - head_q) > rel_sq;
    end
  end

  always_comb begin
    count_d = count_q;
    if (squash_ok) begin
      count_d = (N+1)'(rel_sq) + (N+1)'(1) - (N+1)'(commit_val);
    end else begin
      count_d = count_q + (N+1)'(alloc_fire) - (N+1)'(commit_val);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_q <= '0;
      done_q  <= '0;
      wen_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < D; i++) begin
        pc_q[i]    <= '0;
        waddr_q[i] <= '0;
        wdata_q[i] <= '0;
      end
    end else begin
      // Later assignments win: commit and squash override a same-cycle completion
      for (int i = 0; i < D; i++) begin
        if (complete_val && alloc_q[i] && complete_seq_num == N'(i)) begin
          done_q[i]  <= 1'b1;
          pc_q[i]    <= complete_pc;
          waddr_q[i] <= complete_waddr;
          wdata_q[i] <= complete_wdata;
          wen_q[i]   <= complete_wen;
        end
        if (alloc_fire && tail_q == N'(i)) begin
          alloc_q[i] <= 1'b1;
          done_q[i]  <= 1'b0;
        end
        if (commit_val && head_q == N'(i)) begin
          alloc_q[i] <= 1'b0;
          done_q[i]  <= 1'b0;
        end
        if (squash_ok && younger[i]) begin
          alloc_q[i] <= 1'b0;
          done_q[i]  <= 1'b0;
        end
      end
      head_q  <= head_q + N'(commit_val);
      count_q <= count_d;
      if (squash_ok) begin
        tail_q <= squash_seq_num + N'(1);
      end else if (alloc_fire) begin
        tail_q <= tail_q + N'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_commit_unit.sv
// tb/tb_seq_commit_unit.sv - directed vector bench for seq_commit_unit (window depth 8)
module tb_seq_commit_unit;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_val;
  logic          alloc_rdy;
  logic [N-1:0]  alloc_seq_num;
  logic          complete_val;
  logic [N-1:0]  complete_seq_num;
  logic [31:0]   complete_pc;
  logic [4:0]    complete_waddr;
  logic [31:0]   complete_wdata;
  logic          complete_wen;
  logic          squash_val;
  logic [N-1:0]  squash_seq_num;
  logic          commit_val;
  logic [N-1:0]  commit_seq_num;
  logic [31:0]   commit_pc;
  logic [4:0]    commit_waddr;
  logic [31:0]   commit_wdata;
  logic          commit_wen;

  seq_commit_unit #(.p_seq_num_bits(N)) dut (
    .clk(clk), .rst(rst),
    .alloc_val(alloc_val), .alloc_rdy(alloc_rdy), .alloc_seq_num(alloc_seq_num),
    .complete_val(complete_val), .complete_seq_num(complete_seq_num),
    .complete_pc(complete_pc), .complete_waddr(complete_waddr),
    .complete_wdata(complete_wdata), .complete_wen(complete_wen),
    .squash_val(squash_val), .squash_seq_num(squash_seq_num),
    .commit_val(commit_val), .commit_seq_num(commit_seq_num), .commit_pc(commit_pc),
    .commit_waddr(commit_waddr), .commit_wdata(commit_wdata), .commit_wen(commit_wen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         r, a, c, s, chk, rdy, cv;
    logic [N-1:0] cs, ss, tl, hd;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   step = 0;

  function automatic logic [31:0] pc_of(input logic [N-1:0] s);
    return 32'h0000_1000 + {27'b0, s, 2'b00};
  endfunction
  function automatic logic [4:0] waddr_of(input logic [N-1:0] s);
    return {2'b0, s} + 5'd1;
  endfunction
  function automatic logic [31:0] wdata_of(input logic [N-1:0] s);
    return 32'hA5A5_0000 | {29'b0, s};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at step %0d: got %0h expected %0h", nm, step, act, exp);
  endtask

  // r a c cs s ss | chk rdy tail commit_val head
  task automatic v(input bit r, a, c, input int cs, input bit s, input int ss,
                   input bit chk, rdy, input int tl, input bit cv, input int hd);
    vec_t e;
    e.r = r; e.a = a; e.c = c; e.cs = N'(cs); e.s = s; e.ss = N'(ss);
    e.chk = chk; e.rdy = rdy; e.tl = N'(tl); e.cv = cv; e.hd = N'(hd);
    vecs.push_back(e);
  endtask

  task automatic drive(input bit r, a, c, input logic [N-1:0] cs, input bit s, input logic [N-1:0] ss);
    rst = r; alloc_val = a; complete_val = c; complete_seq_num = cs;
    complete_pc = pc_of(cs); complete_waddr = waddr_of(cs);
    complete_wdata = wdata_of(cs); complete_wen = cs[0];
    squash_val = s; squash_seq_num = ss;
  endtask

  task automatic check_payload(input logic [N-1:0] s);
    check("commit_pc", commit_pc, pc_of(s));
    check("commit_wr", {commit_wen, commit_waddr, commit_wdata}, {s[0], waddr_of(s), wdata_of(s)});
  endtask

  initial begin
    int waited;
    drive(1, 0, 0, 0, 0, 0);
    // reset and in-order flow
    v(1,0,0,0,0,0, 0,0,0,0,0); v(0,0,0,0,0,0, 1,1,0,0,0);
    v(0,1,0,0,0,0, 1,1,0,0,0); v(0,1,0,0,0,0, 1,1,1,0,0); v(0,1,0,0,0,0, 1,1,2,0,0);
    v(0,0,1,0,0,0, 1,1,3,0,0); v(0,0,1,1,0,0, 1,1,3,1,0); v(0,0,1,2,0,0, 1,1,3,1,1);
    v(0,0,0,0,0,0, 1,1,3,1,2); v(0,0,0,0,0,0, 1,1,3,0,3);
    // out-of-order completion: oldest finishes last, then back-to-back commits
    for (int t = 3; t <= 6; t++) v(0,1,0,0,0,0, 1,1,t,0,3);
    v(0,0,1,6,0,0, 1,1,7,0,3); v(0,0,1,4,0,0, 1,1,7,0,3); v(0,0,1,5,0,0, 1,1,7,0,3);
    v(0,0,1,3,0,0, 1,1,7,0,3);
    for (int h = 3; h <= 6; h++) v(0,0,0,0,0,0, 1,1,7,1,h);
    v(0,0,0,0,0,0, 1,1,7,0,7);
    // fill the window across the wrap, refusal at full, refusal despite same-cycle commit
    for (int k = 0; k < 8; k++) v(0,1,0,0,0,0, 1,1,(7+k)%8,0,7);
    v(0,1,0,0,0,0, 1,0,7,0,7); v(0,1,1,7,0,0, 1,0,7,0,7); v(0,1,0,0,0,0, 1,0,7,1,7);
    v(0,1,0,0,0,0, 1,1,7,0,0); v(0,0,1,0,0,0, 1,0,0,0,0); v(0,0,1,1,0,0, 1,0,0,1,0);
    // alloc + commit at count D-1 keeps alloc_rdy high
    v(0,1,1,2,0,0, 1,1,0,1,1);
    for (int h = 2; h <= 6; h++) v(0,0,1,h+1,0,0, 1,1,1,1,h);
    v(0,0,0,0,0,0, 1,1,1,1,7); v(0,0,1,0,0,0, 1,1,1,0,0); v(0,0,0,0,0,0, 1,1,1,1,0);
    v(0,0,0,0,0,0, 1,1,1,0,1);
    // squash with simultaneous commit and completion to a squashed number
    for (int t = 1; t <= 6; t++) v(0,1,0,0,0,0, 1,1,t,0,1);
    v(0,0,1,1,0,0, 1,1,7,0,1); v(0,1,1,5,1,3, 1,0,7,1,1); v(0,1,0,0,0,0, 1,1,4,0,2);
    v(0,0,1,5,0,0, 1,1,5,0,2); v(0,0,1,2,0,0, 1,1,5,0,2); v(0,0,1,3,0,0, 1,1,5,1,2);
    v(0,0,1,4,0,0, 1,1,5,1,3); v(0,0,0,0,0,0, 1,1,5,1,4); v(0,0,0,0,0,0, 1,1,5,0,5);
    // squash naming an unallocated number is ignored
    v(0,0,0,0,1,7, 1,0,5,0,5); v(0,1,0,0,0,0, 1,1,5,0,5); v(0,0,1,5,0,0, 1,1,6,0,5);
    v(0,0,0,0,0,0, 1,1,6,1,5); v(0,0,0,0,0,0, 1,1,6,0,6);
    // reset mid-flight discards allocations and completions
    for (int t = 6; t <= 10; t++) v(0,1,0,0,0,0, 1,1,t%8,0,6);
    v(0,0,1,0,0,0, 1,1,3,0,6); v(0,0,1,1,0,0, 1,1,3,0,6); v(1,0,0,0,0,0, 0,0,0,0,0);
    v(0,0,0,0,0,0, 1,1,0,0,0); v(0,1,0,0,0,0, 1,1,0,0,0); v(0,0,0,0,0,0, 1,1,1,0,0);
    v(0,0,1,0,0,0, 1,1,1,0,0); v(0,0,0,0,0,0, 1,1,1,1,0); v(0,0,0,0,0,0, 1,1,1,0,1);

    foreach (vecs[i]) begin
      @(negedge clk);
      step = i;
      drive(vecs[i].r, vecs[i].a, vecs[i].c, vecs[i].cs, vecs[i].s, vecs[i].ss);
      #1;
      if (vecs[i].chk) begin
        check("alloc_rdy", 32'(alloc_rdy), 32'(vecs[i].rdy));
        check("alloc_seq_num", 32'(alloc_seq_num), 32'(vecs[i].tl));
        check("commit_val", 32'(commit_val), 32'(vecs[i].cv));
        check("commit_seq_num", 32'(commit_seq_num), 32'(vecs[i].hd));
        if (vecs[i].cv) check_payload(vecs[i].hd);
      end
    end

    // hand sequence: head=tail=1; grant 1, complete it, expect its commit within a bounded wait
    step = 1000;
    @(negedge clk); drive(0, 1, 0, 0, 0, 0); #1;
    check("hand_grant", 32'(alloc_seq_num), 32'd1);
    @(negedge clk); drive(0, 0, 1, 1, 0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0); #1;
    waited = 0;
    while (!commit_val && waited < 5) begin
      @(negedge clk); #1; waited++;
    end
    check("hand_commit_latency", 32'(waited), 32'd0);
    check("hand_commit_seq", 32'(commit_seq_num), 32'd1);
    check_payload(3'd1);
    @(negedge clk); #1;
    check("hand_drained", 32'(commit_val), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
